blink_seq_ctrl: RTL and testbench
=================================

Name: blink_seq_ctrl

Overview:
- Sequencer for the LED blink datapath. It owns the 1 ms prescaler and the ms period counter, and drives LEDG8.
- Periods are loaded from switches into a small period table with KEY1.
- KEY2 starts and stops a run. A run steps through the table, holding each slot for a fixed number of LED toggles, then advancing with wrap-around.

Parameters:
- CLK_PER_MS, 50000: clk cycles per 1 ms tick (the prescaler counts 0..CLK_PER_MS-1).
- SLOTS, 4: period table depth, power of 2.
- TOGGLES_PER_SLOT, 8: LED toggles spent on one slot before advancing.
- PERIOD_W, 12: period width in ms.
- DEBOUNCE_MS, 10: debounce window in ms (used only with BTN_DEBOUNCE_EN).

Ports:
- clk, input, 1: system clock (CLOCK_50).
- rst_n, input, 1: asynchronous active-low reset.
- KEY1, input, 1: raw load button, active-low.
- KEY2, input, 1: raw run/stop button, active-low.
- switches, input, 14: period source; the period is switches[13:2].
- LEDG8, output, 1: blink output.
- slot_idx, output, log2(SLOTS): slot currently playing in RUN, or next write slot in IDLE.
- running, output, 1: high while in RUN.

Behaviour:
- Reset (async, rst_n=0):
  - LEDG8=0, running=0, slot_idx=0, wr_ptr=0.
  - All table entries=0; prescaler, ms counter and toggle counter=0.
  - Synchronizer flops reset to 1 (button released).
- Button path, per key:
  - Two-flop synchronizer, then a registered falling-edge detect, giving a 1-cycle press pulse.
  - The pulse is high on the 3rd rising edge after the first edge at which KEYx is sampled low.
  - Held buttons give exactly one pulse. Releases give none.
- FSM states: IDLE, RUN.
- IDLE:
  - LEDG8=0 and counters held at 0. slot_idx shows wr_ptr.
  - load pulse: table[wr_ptr] <= switches[13:2]; wr_ptr <= wr_ptr+1, wrapping SLOTS-1 -> 0.
  - run pulse: go to RUN with play slot=0, counters=0, LEDG8=0. The transition takes effect on the next edge.
- RUN:
  - Prescaler counts 0..CLK_PER_MS-1; ms_tick is asserted when prescaler==CLK_PER_MS-1.
  - ms counter increments on ms_tick.
  - When ms counter==table[slot]-1 and ms_tick: LEDG8 toggles, ms counter <= 0, toggle counter +1.
  - LED half-period is therefore exactly table[slot] ms.
  - When the toggle that makes the toggle count reach TOGGLES_PER_SLOT occurs:
    - slot <= slot+1 (wraps), toggle counter <= 0, ms counter <= 0.
    - LEDG8 keeps its toggled value.
  - table[slot]==0: the slot is skipped; slot advances on the next cycle with no LED change.
  - A skip counter counts consecutive skipped slots and clears on any non-zero slot. If it reaches SLOTS (all entries zero), go to IDLE with LEDG8=0.
  - load pulses are ignored in RUN and the table is frozen.
  - run pulse: go to IDLE; LEDG8=0 and counters cleared on the next edge; wr_ptr unchanged.
- Simultaneous load and run pulses in IDLE: run wins and the load is dropped. Neither the table nor wr_ptr changes.
- Width rules:
  - ms counter is PERIOD_W bits. The maximum period 4095 ms must work with no overflow.
  - Prescaler width is clog2(CLK_PER_MS).
- Reset mid-run: everything returns to reset values immediately, including table contents.

Optional Feature:
- Macro BTN_DEBOUNCE_EN.
- Defined: each synchronized key must hold a new level for DEBOUNCE_MS consecutive ms ticks before the filtered level changes. The filter has its own free-running prescaler, active in all states. The edge detector runs on the filtered level, so press latency is the 3-cycle figure above plus the debounce window.
- Undefined: no filter; the edge detector runs directly on the synchronizer output with the 3-cycle latency.

Test Plan:
- Reset and load. Setup: CLK_PER_MS=4, switches=14'h000C (period 3); KEY1 pressed for 20 cycles. Required: table[0]=3, wr_ptr=1, slot_idx=1, exactly one write, LEDG8=0.
- Basic run. Setup: load periods 3,0,2,5, then press KEY2. Required:
  - running=1.
  - First LEDG8 toggle 12 cycles after RUN entry.
  - 8 toggles spaced 12 cycles apart, then slot 1 is skipped in 1 cycle.
  - Slot 2 toggles every 8 cycles.
- Wrap-around. Setup: run through slots 0..3. Required: slot_idx returns to 0 after slot 3's 8th toggle; LEDG8 keeps its level across the advance.
- All-zero table. Setup: reset, press KEY2. Required: running goes 1, then returns to 0 within SLOTS+2 cycles; LEDG8 stays 0.
- Stop and collision. Setup: press KEY2 mid-slot, then press KEY1 and KEY2 on the same cycle in IDLE. Required:
  - The stop gives running=0 and LEDG8=0.
  - The same-cycle pair enters RUN with the table unchanged and wr_ptr unchanged.
- Async reset. Setup: deassert rst_n to 0 mid-RUN, between clock edges. Required: LEDG8=0, running=0, slot_idx=0 without waiting for a clk edge.

Source files
------------

// File: rtl/blink_seq_ctrl.sv
// Blink sequencer: button sync/edge detect, period table, 1 ms prescaler and per-slot LED toggling (BTN_DEBOUNCE_EN adds a key filter).
// Latency: press pulse 3 cycles after a key is sampled low (plus DEBOUNCE_MS ticks when filtered); state change on the following edge.
// Backpressure: none; press pulses are single-cycle and acted on (or dropped) in the cycle they appear.
module blink_seq_ctrl #(
    parameter int CLK_PER_MS       = 50000,
    parameter int SLOTS            = 4,
    parameter int TOGGLES_PER_SLOT = 8,
    parameter int PERIOD_W         = 12,
    parameter int DEBOUNCE_MS      = 10,
    localparam int SLOT_W          = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              KEY1,
    input  logic              KEY2,
    input  logic [13:0]       switches,
    output logic              LEDG8,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              running
);

    localparam int PRE_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int TOG_W  = $clog2(TOGGLES_PER_SLOT + 1);
    localparam int SKIP_W = $clog2(SLOTS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    // bit 0 = KEY1 (load), bit 1 = KEY2 (run/stop)
    logic [1:0] key_sync1, key_sync2, key_filt, key_prev, key_press;
    logic       load_pls, run_pls;
    logic       unused_sw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync1 <= 2'b11;
            key_sync2 <= 2'b11;
            key_prev  <= 2'b11;
            key_press <= 2'b00;
        end else begin
            key_sync1 <= {KEY2, KEY1};
            key_sync2 <= key_sync1;
            key_prev  <= key_filt;
            key_press <= key_prev & ~key_filt;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);

    logic [PRE_W-1:0] db_pre;
    logic             db_tick;
    logic [DB_W-1:0]  db_cnt [2];
    logic [1:0]       db_level;

    assign db_tick  = (db_pre == PRE_W'(CLK_PER_MS - 1));
    assign key_filt = db_level;

    // A key's filtered level flips only after the new level survives DEBOUNCE_MS ticks in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_pre   <= '0;
            db_level <= 2'b11;
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
        end else begin
            db_pre <= db_tick ? '0 : db_pre + PRE_W'(1);
            for (int k = 0; k < 2; k++) begin
                if (key_sync2[k] == db_level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_tick) begin
                    if (db_cnt[k] == DB_W'(DEBOUNCE_MS - 1)) begin
                        db_level[k] <= key_sync2[k];
                        db_cnt[k]   <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + DB_W'(1);
                    end
                end
            end
        end
    end
`else
    assign key_filt = key_sync2;
`endif

    assign load_pls  = key_press[0];
    assign run_pls   = key_press[1];
    assign unused_sw = ^switches[1:0];

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] period_tbl [SLOTS];
    logic [SLOT_W-1:0]   wr_ptr, play_slot;
    logic [PRE_W-1:0]    presc;
    logic [PERIOD_W-1:0] ms_cnt;
    logic [TOG_W-1:0]    tog_cnt;
    logic [SKIP_W-1:0]   skip_cnt;
    logic                led_q;

    logic [PERIOD_W-1:0] cur_per;
    logic                slot_zero, ms_tick, ms_done, slot_done, all_skip;
    logic [SLOT_W-1:0]   wr_ptr_inc, play_slot_inc;

    assign cur_per       = period_tbl[play_slot];
    assign slot_zero     = (cur_per == '0);
    assign ms_tick       = (presc == PRE_W'(CLK_PER_MS - 1));
    assign ms_done       = ms_tick && (ms_cnt == cur_per - PERIOD_W'(1));
    assign slot_done     = ms_done && (tog_cnt == TOG_W'(TOGGLES_PER_SLOT - 1));
    assign all_skip      = slot_zero && (skip_cnt == SKIP_W'(SLOTS - 1));
    assign wr_ptr_inc    = (wr_ptr == SLOT_W'(SLOTS - 1)) ? '0 : wr_ptr + SLOT_W'(1);
    assign play_slot_inc = (play_slot == SLOT_W'(SLOTS - 1)) ? '0 : play_slot + SLOT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run_pls) state_nxt = RUN;
            RUN:     if (run_pls || all_skip) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) period_tbl[i] <= '0;
            wr_ptr    <= '0;
            play_slot <= '0;
            presc     <= '0;
            ms_cnt    <= '0;
            tog_cnt   <= '0;
            skip_cnt  <= '0;
            led_q     <= 1'b0;
        end else if (state == IDLE || run_pls || all_skip) begin
            // Idle, or leaving RUN: everything playback-related sits at zero.
            play_slot <= '0;
            presc     <= '0;
            ms_cnt    <= '0;
            tog_cnt   <= '0;
            skip_cnt  <= '0;
            led_q     <= 1'b0;
            if (state == IDLE && load_pls && !run_pls) begin
                period_tbl[wr_ptr] <= PERIOD_W'(switches[13:2]);
                wr_ptr             <= wr_ptr_inc;
            end
        end else begin
            presc <= ms_tick ? '0 : presc + PRE_W'(1);
            if (slot_zero) begin
                play_slot <= play_slot_inc;
                skip_cnt  <= skip_cnt + SKIP_W'(1);
                ms_cnt    <= '0;
                tog_cnt   <= '0;
            end else begin
                skip_cnt <= '0;
                if (ms_done) begin
                    led_q  <= ~led_q;
                    ms_cnt <= '0;
                    if (slot_done) begin
                        tog_cnt   <= '0;
                        play_slot <= play_slot_inc;
                    end else begin
                        tog_cnt <= tog_cnt + TOG_W'(1);
                    end
                end else if (ms_tick) begin
                    ms_cnt <= ms_cnt + PERIOD_W'(1);
                end
            end
        end
    end

    assign LEDG8    = led_q;
    assign running  = (state == RUN);
    assign slot_idx = (state == RUN) ? play_slot : wr_ptr;

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// Bench for blink_seq_ctrl: load-vector table, scripted corner cases, random runs against an event-level model.
module tb_blink_seq_ctrl;
    localparam int CPM   = 4;
    localparam int SLOTS = 4;
    localparam int TPS   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        KEY1 = 1'b1;
    logic        KEY2 = 1'b1;
    logic [13:0] switches = '0;
    logic        LEDG8;
    logic [1:0]  slot_idx;
    logic        running;

    blink_seq_ctrl #(
        .CLK_PER_MS(CPM), .SLOTS(SLOTS), .TOGGLES_PER_SLOT(TPS), .PERIOD_W(12), .DEBOUNCE_MS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .KEY1(KEY1), .KEY2(KEY2), .switches(switches),
        .LEDG8(LEDG8), .slot_idx(slot_idx), .running(running)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: table contents, write pointer and playback position in ms/toggle units.
    int m_tbl [SLOTS];
    int m_wr, m_slot, m_ms, m_tog, m_skip;
    bit m_led, m_run;
    int tq[$];
    int sl_trace[$];

    task automatic model_clear();
        for (int i = 0; i < SLOTS; i++) m_tbl[i] = 0;
        m_wr = 0;
    endtask

    // Cycle c counts from RUN entry; a 1 ms tick falls in every CPM-th cycle.
    task automatic m_step(input int c);
        if (!m_run) return;
        if (m_tbl[m_slot] == 0) begin
            m_skip++;
            if (m_skip == SLOTS) begin
                m_run = 0;
                m_led = 0;
            end else begin
                m_slot = (m_slot + 1) % SLOTS;
            end
        end else begin
            m_skip = 0;
            if (c % CPM == CPM - 1) begin
                if (m_ms == m_tbl[m_slot] - 1) begin
                    m_led = !m_led;
                    m_ms  = 0;
                    m_tog++;
                    if (m_tog == TPS) begin
                        m_tog  = 0;
                        m_slot = (m_slot + 1) % SLOTS;
                    end
                end else begin
                    m_ms++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic load(input int per, input int hold);
        int old;
        old = m_wr;
        switches = {12'(per), 2'b00};
        KEY1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("load_latency", slot_idx, old);
        @(negedge clk);
        chk("load_wr", slot_idx, (old + 1) % SLOTS);
        repeat (hold - 4) @(negedge clk);
        KEY1 = 1'b1;
        repeat (4) @(negedge clk);
        chk("load_once", slot_idx, (old + 1) % SLOTS);
        chk("load_tbl", dut.period_tbl[old], per);
        chk("load_led", LEDG8, 0);
        chk("load_running", running, 0);
        m_tbl[old] = per;
        m_wr = (old + 1) % SLOTS;
    endtask

    task automatic start_run();
        KEY2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("run_latency", running, 0);
        @(negedge clk);
        chk("run_entry", running, 1);
        KEY2 = 1'b1;
    endtask

    task automatic stop_run();
        KEY2 = 1'b0;
        repeat (4) @(negedge clk);
        KEY2 = 1'b1;
        chk("stop_running", running, 0);
        chk("stop_led", LEDG8, 0);
        chk("stop_slot", slot_idx, m_wr);
        @(negedge clk);
    endtask

    task automatic run_model(input int ncyc, input bit rand_k1);
        logic prev;
        m_run = 1; m_slot = 0; m_ms = 0; m_tog = 0; m_skip = 0; m_led = 0;
        tq.delete();
        sl_trace.delete();
        prev = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            chk("run_running", running, m_run);
            chk("run_led", LEDG8, m_led);
            chk("run_slot", slot_idx, m_run ? m_slot : m_wr);
            if (LEDG8 !== prev) tq.push_back(n);
            prev = LEDG8;
            sl_trace.push_back(int'(slot_idx));
            if (rand_k1 && n < ncyc - 10) begin
                KEY1 = ($urandom_range(0, 5) != 0);
                switches = 14'($urandom);
            end else begin
                KEY1 = 1'b1;
            end
            m_step(n);
            @(negedge clk);
        end
    endtask

    typedef struct {
        int per;
        int hold;
        int exp_idx;
    } load_vec_t;

    load_vec_t vecs [4];

    initial begin
        int cnt;
        bit nz;
        int p;

        vecs[0] = '{3, 20, 1};
        vecs[1] = '{0, 5, 2};
        vecs[2] = '{2, 6, 3};
        vecs[3] = '{5, 4, 0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_led", LEDG8, 0);
        chk("rst_running", running, 0);
        chk("rst_slot", slot_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);

        // Load table 3,0,2,5 (first press held 20 cycles)
        for (int i = 0; i < 4; i++) begin
            load(vecs[i].per, vecs[i].hold);
            chk("vec_idx", slot_idx, vecs[i].exp_idx);
        end

        // Basic run with wrap-around; KEY1 activity in RUN must be ignored
        start_run();
        run_model(340, 1'b1);
        chk("tq_size", tq.size() >= 24, 1);
        if (tq.size() >= 24) begin
            for (int k = 0; k < 8; k++) chk("slot0_toggle", tq[k], 12 * (k + 1));
            for (int k = 0; k < 8; k++) chk("slot2_toggle", tq[8 + k], 104 + 8 * k);
            chk("slot3_first", tq[16], 180);
            chk("slot3_last", tq[23], 320);
        end
        chk("skip_slot1", sl_trace[96], 1);
        chk("skip_done", sl_trace[97], 2);
        chk("wrap_pre", sl_trace[319], 3);
        chk("wrap_slot", sl_trace[320], 0);
        for (int i = 0; i < SLOTS; i++) chk("tbl_frozen", dut.period_tbl[i], m_tbl[i]);

        // Stop mid-slot, then simultaneous load+run in IDLE
        stop_run();
        switches = {12'd7, 2'b00};
        KEY1 = 1'b0;
        KEY2 = 1'b0;
        repeat (4) @(negedge clk);
        KEY1 = 1'b1;
        KEY2 = 1'b1;
        chk("collide_running", running, 1);
        chk("collide_wr", dut.wr_ptr, 0);
        @(negedge clk);
        for (int i = 0; i < SLOTS; i++) chk("collide_tbl", dut.period_tbl[i], m_tbl[i]);

        // Async reset mid-run while LED is high
        cnt = 0;
        while (LEDG8 !== 1'b1 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        chk("led_high_seen", LEDG8, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", LEDG8, 0);
        chk("arst_running", running, 0);
        chk("arst_slot", slot_idx, 0);
        chk("arst_tbl", dut.period_tbl[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);

        // All-zero table: RUN must fall back to IDLE with LED low
        start_run();
        cnt = 0;
        while (running === 1'b1 && cnt < 20) begin
            chk("allzero_led", LEDG8, 0);
            @(negedge clk);
            cnt++;
        end
        chk("allzero_bound", (cnt >= 1) && (cnt <= SLOTS + 2), 1);
        chk("allzero_led_end", LEDG8, 0);

        // Maximum period: first toggle exactly 4095 ms after entry
        load(4095, 5);
        start_run();
        cnt = 0;
        while (LEDG8 === 1'b0 && running === 1'b1 && cnt < 17000) begin
            @(negedge clk);
            cnt++;
        end
        chk("max_period", cnt, 4095 * CPM);
        chk("max_slot", slot_idx, 0);
        stop_run();

        // Randomised tables checked against the model
        for (int it = 0; it < 3; it++) begin
            do_reset();
            nz = 0;
            for (int i = 0; i < SLOTS; i++) begin
                p = $urandom_range(0, 4);
                if (p != 0) nz = 1;
                load(p, $urandom_range(4, 8));
            end
            start_run();
            run_model(200, nz);
            if (running === 1'b1) stop_run();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
